hf_line_writer: RTL and testbench
=================================

HF_LINE_WRITER -- requirements
Module: hf_line_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, pair FIFO depth, a power of two and at least 2.
REQ-002 SHALL have parameter ADDR_W, default 10, write-address width.
REQ-003 SHALL have port clk input 1: single clock, rising edge.
REQ-004 SHALL have port rst_n input 1: asynchronous active-low reset.
REQ-005 SHALL have port start input 1: one-cycle pulse that begins a granule.
REQ-006 SHALL have port big_values input 10: number of pairs in the big_values region.
REQ-007 SHALL have port pair_valid input 1: decoded pair present (driven by Huffman decoder axiov).
REQ-008 SHALL have port x_val input 16 signed: first value of the pair.
REQ-009 SHALL have port y_val input 16 signed: second value of the pair.
REQ-010 SHALL have port pair_ready output 1: FIFO can accept a pair; used to stall the upstream bit feed.
REQ-011 SHALL have port wr_en output 1: line-buffer write strobe.
REQ-012 SHALL have port wr_addr output ADDR_W: frequency-line index, 0..575.
REQ-013 SHALL have port wr_data output 16 signed: line value.
REQ-014 SHALL have port busy output 1: high in any state other than IDLE.
REQ-015 SHALL have port done output 1: one-cycle pulse after line 575 is written.
REQ-016 SHALL have port overflow output 1: sticky flag, pair lost.

Function
REQ-017 FSM states SHALL be IDLE, WRITE_X, WRITE_Y, ZERO, DONE.
REQ-018 IDLE + start SHALL latch min(big_values, 288) as pair_target, clear line index and overflow, and go to WRITE_X; go to ZERO instead if the target is 0.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 pair_ready SHALL equal busy AND NOT fifo_full AND (pairs_accepted < pair_target).
REQ-021 A pair SHALL be pushed when pair_valid AND pair_ready.
REQ-022 pair_valid while busy with pair_ready low SHALL drop the pair and set overflow.
REQ-023 pair_valid in IDLE SHALL be ignored, with no flag.
REQ-024 WRITE_X with FIFO non-empty SHALL assert wr_en with wr_addr=line, wr_data=x of the head pair, then go to WRITE_Y.
REQ-025 WRITE_Y SHALL write the y of the head pair at line+1, pop the FIFO, and advance line by 2.
REQ-026 After the pair_target-th pop, WRITE_Y SHALL go to ZERO; otherwise it SHALL return to WRITE_X.
REQ-027 WRITE_X with an empty FIFO SHALL hold, wr_en low.
REQ-028 Latency: a pair accepted in cycle N into an empty FIFO SHALL produce the x write in N+1 and the y write in N+2.
REQ-029 A simultaneous push and pop SHALL be legal; FIFO count SHALL be unchanged.
REQ-030 ZERO SHALL write 0 to each line from 2*pair_target to 575, one per cycle, then go to DONE.
REQ-031 DONE SHALL pulse done for exactly one cycle and return to IDLE.
REQ-032 wr_en, wr_addr and wr_data SHALL be registered outputs.
REQ-033 wr_addr SHALL never exceed 575.
REQ-034 Exactly 576 writes SHALL occur per granule.

Reset
REQ-035 On rst_n low, asynchronously: state=IDLE; FIFO empty; line=0; wr_en=0; wr_addr=0; wr_data=0; done=0; overflow=0.
REQ-036 Reset mid-granule SHALL abort it with no done pulse.
REQ-037 pair_ready SHALL be 0 during reset.

Configuration
REQ-038 With HF_LINE_WRITER_CLAMP_EN defined, wr_data SHALL be saturated to the range -8206..+8206 before write, and overflow SHALL also be set on any clamp.
REQ-039 Without HF_LINE_WRITER_CLAMP_EN, values SHALL pass unmodified.

Structure
REQ-040 Package hf_pkg SHALL hold NUM_LINES=576, MAX_PAIRS=288, MAX_ABS=8206, and the state enum hlw_state_t.
REQ-041 Sub-module hlw_pair_fifo SHALL implement the synchronous pair FIFO (32-bit entries {x,y}; full, empty, count).

Verification
REQ-042 Scenario 1: big_values=2, pairs (3,-1) and (0,5) arriving back-to-back -> writes addr0=3, 1=-1, 2=0, 3=5, zeros at 4..575, done once.
REQ-043 Scenario 2: big_values=0 -> 576 zero writes, done 577 cycles after start.
REQ-044 Scenario 3: big_values=300 -> clamps to 288 pairs; pair_ready low after the 288th accept; no zero writes.
REQ-045 Scenario 4: pair_valid held every cycle, FIFO_DEPTH=4 -> pair_ready deasserts; a forced extra pair sets overflow; ordering otherwise preserved.
REQ-046 Scenario 5: rst_n low at line 100 -> all outputs 0 immediately; a new start runs a clean granule.
REQ-047 Scenario 6: with HF_LINE_WRITER_CLAMP_EN, x_val=9000 -> wr_data=8206 and overflow=1; without the macro, wr_data=9000.

Source files
------------

// File: rtl/hf_pkg.sv
// Shared constants and state type for the Huffman line writer.
package hf_pkg;
  localparam int NUM_LINES = 576;
  localparam int MAX_PAIRS = 288;
  localparam int MAX_ABS   = 8206;
  localparam int LINE_W    = 10;
  localparam int PAIR_W    = 9;

  typedef enum logic [2:0] {
    IDLE,
    WRITE_X,
    WRITE_Y,
    ZERO,
    DONE
  } hlw_state_t;
endpackage

// File: rtl/hlw_pair_fifo.sv
// Synchronous FIFO of decoded {x,y} pairs; storage is not reset, only pointers and count.
module hlw_pair_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [31:0]              din,
  input  logic                     pop,
  output logic [31:0]              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout  = mem_q[rptr_q];
  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
endmodule

// File: rtl/hf_line_writer.sv
// Streams decoded Huffman pairs into 576 frequency lines, zero-filling the tail.
// Optional macro HF_LINE_WRITER_CLAMP_EN saturates written values to +/-MAX_ABS.
module hf_line_writer
  import hf_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [9:0]               big_values,
  input  logic                     pair_valid,
  input  logic signed [15:0]       x_val,
  input  logic signed [15:0]       y_val,
  output logic                     pair_ready,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [15:0]       wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);
  hlw_state_t state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [PAIR_W-1:0] target_q, target_d, acc_q, acc_d;
  logic ovf_q, ovf_d, wr_en_q, wr_en_d, done_q, done_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic signed [15:0] wr_data_q, wr_data_d;

  logic push, pop, fifo_full, fifo_empty;
  logic [31:0] fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;
  logic signed [15:0] head_x, head_y, x_line, y_line;
  logic clip_x, clip_y;

  assign busy       = (state_q != IDLE);
  assign pair_ready = busy && !fifo_full && (acc_q < target_q);
  assign push       = pair_valid && pair_ready;
  assign pop        = (state_q == WRITE_Y);
  assign head_x     = fifo_dout[31:16];
  assign head_y     = fifo_dout[15:0];

  hlw_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({x_val, y_val}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

`ifdef HF_LINE_WRITER_CLAMP_EN
  localparam logic signed [15:0] LIM = 16'(MAX_ABS);

  function automatic logic signed [15:0] sat_line(input logic signed [15:0] v);
    if (v > LIM)  return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  assign x_line = sat_line(head_x);
  assign y_line = sat_line(head_y);
  assign clip_x = (x_line != head_x);
  assign clip_y = (y_line != head_y);
`else
  assign x_line = head_x;
  assign y_line = head_y;
  assign clip_x = 1'b0;
  assign clip_y = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    target_d  = target_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    if (push) acc_d = acc_q + 1'b1;
    if (pair_valid && busy && !pair_ready) ovf_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          target_d = (big_values > 10'(MAX_PAIRS)) ? PAIR_W'(MAX_PAIRS) : big_values[PAIR_W-1:0];
          line_d   = '0;
          acc_d    = '0;
          ovf_d    = 1'b0;
          state_d  = (big_values == '0) ? ZERO : WRITE_X;
        end
      end
      WRITE_X: begin
        if (!fifo_empty) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_W'(line_q);
          wr_data_d = x_line;
          if (clip_x) ovf_d = 1'b1;
          state_d   = WRITE_Y;
        end
      end
      WRITE_Y: begin
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_W'(line_q + 10'd1);
        wr_data_d = y_line;
        if (clip_y) ovf_d = 1'b1;
        line_d    = line_q + 10'd2;
        state_d   = (line_q + 10'd2 == {target_q, 1'b0}) ? ZERO : WRITE_X;
      end
      ZERO: begin
        // A full 288-pair granule arrives here with line already at 576: no write, straight to DONE.
        if (line_q < LINE_W'(NUM_LINES)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_W'(line_q);
          wr_data_d = '0;
          line_d    = line_q + 10'd1;
        end
        if (line_q >= LINE_W'(NUM_LINES - 1)) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      line_q    <= '0;
      target_q  <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      target_q  <= target_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_hf_line_writer.sv
// Bench for hf_line_writer: table of granules with random pairs plus directed corner sequences.
module tb_hf_line_writer;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pair_valid = 1'b0;
  logic [9:0] big_values = '0;
  logic signed [15:0] x_val = '0, y_val = '0;
  logic pair_ready, wr_en, busy, done, overflow;
  logic [9:0] wr_addr;
  logic signed [15:0] wr_data;

  hf_line_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .big_values(big_values),
    .pair_valid(pair_valid), .x_val(x_val), .y_val(y_val),
    .pair_ready(pair_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; int c; } wr_t;
  wr_t wq[$];
  int acc_x[$], acc_y[$], acc_c[$], done_c[$];
  int src_x[$], src_y[$];
  bit drop_seen, bp_seen;
  int ready_viol, mon_target;

  // Observation at the falling edge, well away from the rising edge.
  always @(negedge clk) begin
    if (wr_en) wq.push_back('{int'(wr_addr), int'(wr_data), cyc});
    if (done) done_c.push_back(cyc);
    if (busy && pair_ready && acc_x.size() >= mon_target) ready_viol++;
    if (busy && !pair_ready && acc_x.size() < mon_target) bp_seen = 1;
    if (pair_valid && busy && !pair_ready) drop_seen = 1;
    if (pair_valid && pair_ready) begin
      acc_x.push_back(int'(x_val));
      acc_y.push_back(int'(y_val));
      acc_c.push_back(cyc + 1);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_line(input int v);
`ifdef HF_LINE_WRITER_CLAMP_EN
    if (v > 8206) return 8206;
    if (v < -8206) return -8206;
`endif
    return v;
  endfunction

  task automatic clear_mon(input int tgt);
    wq.delete(); acc_x.delete(); acc_y.delete(); acc_c.delete(); done_c.delete();
    drop_seen = 0; bp_seen = 0; ready_viol = 0; mon_target = tgt;
  endtask

  task automatic fill_random(input int n);
    src_x.delete(); src_y.delete();
    for (int i = 0; i < n; i++) begin
      src_x.push_back(int'($urandom_range(16412)) - 8206);
      src_y.push_back(int'($urandom_range(16412)) - 8206);
    end
  endtask

  // ff=1 fires pairs every chosen cycle regardless of pair_ready (lost pairs vanish).
  task automatic run_granule(input int bv, input int tgt, input int pct, input bit ff,
                             input int stop_addr, input int poke, input string tag,
                             output int start_c);
    int n = 0;
    bit stopped = 0;
    clear_mon(tgt);
    big_values = 10'(bv);
    start = 1'b1;
    start_c = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done_c.size() == 0 && n < 3000 && !stopped) begin
      if (stop_addr >= 0 && wr_en && int'(wr_addr) == stop_addr) stopped = 1;
      else begin
        start = (n == poke);
        if (src_x.size() > 0 && (ff || pair_ready) && int'($urandom_range(99)) < pct) begin
          pair_valid = 1'b1;
          x_val = 16'(src_x[0]);
          y_val = 16'(src_y[0]);
        end else pair_valid = 1'b0;
        @(posedge clk);
        if (pair_valid) begin
          void'(src_x.pop_front());
          void'(src_y.pop_front());
        end
        #1;
        n++;
      end
    end
    start = 1'b0;
    pair_valid = 1'b0;
    if (!stopped && done_c.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s done_timeout: got no done in 3000 cycles, expected one", tag);
    end
  endtask

  task automatic verify(input string tag, input int tgt);
    int exp[576];
    bit expovf;
    int bad, nacc;
    repeat (3) @(posedge clk);
    #1;
    expovf = drop_seen;
    bad = -1;
    nacc = acc_x.size();
    foreach (exp[i]) exp[i] = 0;
    for (int k = 0; k < nacc && k < 288; k++) begin
      exp[2*k]   = model_line(acc_x[k]);
      exp[2*k+1] = model_line(acc_y[k]);
      if (exp[2*k] != acc_x[k] || exp[2*k+1] != acc_y[k]) expovf = 1;
    end
    chk({tag, " accepted"}, nacc, tgt);
    chk({tag, " writes"}, wq.size(), 576);
    for (int i = 0; i < 576; i++)
      if (i >= wq.size() || wq[i].addr != i || wq[i].data != exp[i]) begin bad = i; break; end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s lines: write %0d got addr %0d data %0d, expected addr %0d data %0d", tag, bad,
               (bad < wq.size()) ? wq[bad].addr : -1, (bad < wq.size()) ? wq[bad].data : 0, bad, exp[bad]);
    end
    chk({tag, " done_once"}, done_c.size(), 1);
    chk({tag, " overflow"}, int'(overflow), int'(expovf));
    chk({tag, " ready_after_target"}, ready_viol, 0);
    chk({tag, " busy_after_done"}, int'(busy), 0);
  endtask

  typedef struct { int bv; int exp_pairs; int pct; int exp_ovf; } vec_t;

  initial begin
    vec_t tbl[7];
    int sc;

    tbl[0] = '{0, 0, 60, 0};
    tbl[1] = '{1, 1, 70, 0};
    tbl[2] = '{2, 2, 100, 0};
    tbl[3] = '{37, 37, 50, 0};
    tbl[4] = '{287, 287, 90, 0};
    tbl[5] = '{300, 288, 100, 0};
    tbl[6] = '{1023, 288, 80, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst wr_en", int'(wr_en), 0);
    chk("rst wr_addr", int'(wr_addr), 0);
    chk("rst wr_data", int'(wr_data), 0);
    chk("rst done", int'(done), 0);
    chk("rst overflow", int'(overflow), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst pair_ready", int'(pair_ready), 0);
    rst_n = 1'b1;

    // Pairs offered while idle are ignored without a flag
    pair_valid = 1'b1; x_val = 16'sd77; y_val = -16'sd9;
    repeat (3) @(posedge clk);
    #1;
    pair_valid = 1'b0;
    chk("idle overflow", int'(overflow), 0);
    chk("idle pair_ready", int'(pair_ready), 0);

    for (int i = 0; i < 7; i++) begin
      string tag;
      tag = $sformatf("tbl%0d_bv%0d", i, tbl[i].bv);
      fill_random(320);
      run_granule(tbl[i].bv, tbl[i].exp_pairs, tbl[i].pct, 1'b0, -1, -1, tag, sc);
      verify(tag, tbl[i].exp_pairs);
      chk({tag, " table_ovf"}, int'(overflow), tbl[i].exp_ovf);
    end

    // Two pairs back-to-back: fixed lines and first-pair latency
    src_x = '{3, 0}; src_y = '{-1, 5};
    run_granule(2, 2, 100, 1'b0, -1, -1, "s1", sc);
    verify("s1", 2);
    if (wq.size() >= 4 && acc_c.size() == 2) begin
      chk("s1 line0", wq[0].data, 3);
      chk("s1 line1", wq[1].data, -1);
      chk("s1 line2", wq[2].data, 0);
      chk("s1 line3", wq[3].data, 5);
      chk("s1 back_to_back", acc_c[1] - acc_c[0], 1);
      chk("s1 x_latency", wq[0].c - acc_c[0], 1);
      chk("s1 y_latency", wq[1].c - acc_c[0], 2);
    end else chk("s1 capture_size", wq.size() * 10 + acc_c.size(), 5762);

    // Zero-only granule with a stray start mid-way that must be ignored
    run_granule(0, 0, 0, 1'b0, -1, 100, "s2", sc);
    verify("s2", 0);
    chk("s2 done_latency", (done_c.size() > 0) ? done_c[0] - sc : -1, 577);

    // Pairs fired every cycle: back-pressure, dropped pairs, order of the kept ones
    fill_random(400);
    run_granule(20, 20, 100, 1'b1, -1, -1, "s4", sc);
    verify("s4", 20);
    chk("s4 backpressure_seen", int'(bp_seen), 1);
    chk("s4 overflow_set", int'(overflow), 1);

    // Asynchronous reset in the middle of a granule
    fill_random(400);
    run_granule(100, 100, 100, 1'b1, 100, -1, "s5", sc);
    chk("s5 reached_line100", int'(wr_en && wr_addr == 10'd100), 1);
    chk("s5 overflow_before_reset", int'(overflow), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5 wr_en", int'(wr_en), 0);
    chk("s5 wr_addr", int'(wr_addr), 0);
    chk("s5 wr_data", int'(wr_data), 0);
    chk("s5 overflow", int'(overflow), 0);
    chk("s5 busy", int'(busy), 0);
    chk("s5 pair_ready", int'(pair_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("s5 no_done", done_c.size(), 0);
    chk("s5 ready_in_reset", int'(pair_ready), 0);
    rst_n = 1'b1;
    fill_random(320);
    run_granule(50, 50, 70, 1'b0, -1, -1, "s5_clean", sc);
    verify("s5_clean", 50);

    // Out-of-range value: clamped and flagged only in the clamp build
    src_x = '{9000}; src_y = '{-9000};
    run_granule(1, 1, 100, 1'b0, -1, -1, "s6", sc);
    verify("s6", 1);
`ifdef HF_LINE_WRITER_CLAMP_EN
    chk("s6 x_data", (wq.size() > 0) ? wq[0].data : 0, 8206);
    chk("s6 y_data", (wq.size() > 1) ? wq[1].data : 0, -8206);
    chk("s6 overflow", int'(overflow), 1);
`else
    chk("s6 x_data", (wq.size() > 0) ? wq[0].data : 0, 9000);
    chk("s6 y_data", (wq.size() > 1) ? wq[1].data : 0, -9000);
    chk("s6 overflow", int'(overflow), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
